// File: rtl/key_input_pkg.sv
// Shared definitions for the key input block and the predictor that consumes
// its samples.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EMIT = 2'b01,
    LOCK = 2'b10
  } state_t;

  localparam logic [1:0] XIN_POS = 2'b01;
  localparam logic [1:0] XIN_NEG = 2'b11;

endpackage

// File: rtl/key_input_debounce_key.sv
// One push button: two-flop synchroniser, stable-level debounce and a
// one-cycle press pulse on a debounced 1->0 transition.
module debounce_key #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable_d;
  logic             armed;
  logic [1:0]       warm;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      warm     <= '0;
      armed    <= 1'b0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      stable_d <= stable;
      warm     <= {warm[0], 1'b1};
      // Only arm once the real key has been seen high, so a key held
      // through reset needs a release before it can press again.
      if (warm[1] && sync2 && stable)
        armed <= 1'b1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = armed & stable_d & ~stable;

endmodule

// File: rtl/key_input.sv
// Two debounced push buttons feeding a single +1/-1 sample to a busy-gated
// predictor, counting every press that cannot be accepted.
module key_input
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              key0,
  input  logic              key1,
  input  logic              busy,
  output logic signed [1:0] xin,
  output logic              sample_valid,
  output logic [7:0]        drop_cnt
);

  logic   stable0, stable1;
  logic   press0, press1;
  logic   accept, drop;
  state_t state, state_next;

  debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key0 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .key    (key0),
    .stable (stable0),
    .press  (press0)
  );

  debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key1 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .key    (key1),
    .stable (stable1),
    .press  (press1)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state    <= IDLE;
      xin      <= XIN_POS;
      drop_cnt <= '0;
    end else begin
      state <= state_next;
      // key1 wins a simultaneous press
      if (accept)
        xin <= press1 ? XIN_NEG : XIN_POS;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    sample_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!busy && (press0 || press1)) begin
          accept     = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        sample_valid = 1'b1;
        state_next   = LOCK;
      end
      LOCK: begin
        if (stable0 && stable1 && !busy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    drop = (press0 || press1) && !accept;
  end

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with a short debounce window.
module tb_key_input;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              key0 = 1'b1;
  logic              key1 = 1'b1;
  logic              busy = 1'b0;
  logic signed [1:0] xin;
  logic              sample_valid;
  logic [7:0]        drop_cnt;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int base;

  key_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .key0         (key0),
    .key1         (key1),
    .busy         (busy),
    .xin          (xin),
    .sample_valid (sample_valid),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sample_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
  endtask

  task automatic press_key0(input int low, input int high);
    key0 = 1'b0;
    cycles(low);
    key0 = 1'b1;
    cycles(high);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset_xin", int'(xin), 1);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_drop", int'(drop_cnt), 0);

    // key0 held low for 10 cycles
    base = pulses;
    press_key0(10, 10);
    check("k0_pulses", pulses - base, 1);
    check("k0_xin", int'(xin), 1);
    check("k0_drop", int'(drop_cnt), 0);

    // key1 bouncing every 2 cycles never settles
    do_reset();
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      key1 = ~key1;
      cycles(2);
    end
    key1 = 1'b1;
    cycles(10);
    check("bounce_pulses", pulses - base, 0);
    check("bounce_xin", int'(xin), 1);
    check("bounce_drop", int'(drop_cnt), 0);

    // Both keys fall together: key1 wins, no drop
    do_reset();
    base = pulses;
    key0 = 1'b0;
    key1 = 1'b0;
    cycles(12);
    check("both_pulses", pulses - base, 1);
    check("both_xin", int'(xin), -1);
    check("both_drop", int'(drop_cnt), 0);
    key0 = 1'b1;
    key1 = 1'b1;
    cycles(10);
    check("both_release_pulses", pulses - base, 1);

    // Press while busy is dropped, later press accepted
    busy = 1'b1;
    base = pulses;
    press_key0(8, 8);
    check("busy_drop", int'(drop_cnt), 1);
    check("busy_pulses", pulses - base, 0);
    busy = 1'b0;
    cycles(2);
    press_key0(8, 8);
    check("after_busy_pulses", pulses - base, 1);
    check("after_busy_xin", int'(xin), 1);
    check("after_busy_drop", int'(drop_cnt), 1);

    // Press of key0 while locked on a held key1 is dropped
    base = pulses;
    key1 = 1'b0;
    cycles(10);
    check("lock_k1_pulses", pulses - base, 1);
    press_key0(8, 8);
    check("lock_drop", int'(drop_cnt), 2);
    check("lock_xin", int'(xin), -1);
    check("lock_pulses", pulses - base, 1);
    key1 = 1'b1;
    cycles(10);

    // 300 presses while busy: drop counter saturates
    do_reset();
    busy = 1'b1;
    base = pulses;
    for (int i = 0; i < 300; i++) begin
      press_key0(8, 8);
      if (i == 9) check("drop_10", int'(drop_cnt), 10);
    end
    check("drop_sat", int'(drop_cnt), 255);
    check("drop_sat_pulses", pulses - base, 0);
    busy = 1'b0;
    cycles(5);

    // Reset mid-LOCK with key1 held low
    do_reset();
    base = pulses;
    key1 = 1'b0;
    cycles(10);
    check("pre_rst_pulses", pulses - base, 1);
    check("pre_rst_xin", int'(xin), -1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("rst_lock_xin", int'(xin), 1);
    check("rst_lock_valid", int'(sample_valid), 0);
    cycles(20);
    check("held_pulses", pulses - base, 1);
    check("held_xin", int'(xin), 1);
    key1 = 1'b1;
    cycles(10);
    key1 = 1'b0;
    cycles(10);
    check("repress_pulses", pulses - base, 2);
    check("repress_xin", int'(xin), -1);
    key1 = 1'b1;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
